// File: rtl/spi_mnrch_param_if.sv
// Control and SPI pin bundle for spi_mnrch_param; master = the SPI engine, slave = its environment.
// The lsb_first input exists only when SPI_LSB_FIRST_EN is defined.
interface spi_mnrch_param_if #(
  parameter int DATA_W = 16,
  parameter int NUM_SS = 1
);
  localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              snd;
  logic [DATA_W-1:0] cmd;
  logic [1:0]        mode;
  logic [SEL_W-1:0]  ss_sel;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic              MISO;
  logic [NUM_SS-1:0] SS_n;
  logic              SCLK;
  logic              MOSI;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] resp;

  modport master (
    input  snd, cmd, mode, ss_sel, MISO,
`ifdef SPI_LSB_FIRST_EN
    input  lsb_first,
`endif
    output SS_n, SCLK, MOSI, busy, done, resp
  );

  modport slave (
    output snd, cmd, mode, ss_sel, MISO,
`ifdef SPI_LSB_FIRST_EN
    output lsb_first,
`endif
    input  SS_n, SCLK, MOSI, busy, done, resp
  );
endinterface

// File: rtl/spi_mnrch_param.sv
// Parametrised SPI master: DATA_W-bit full-duplex transfers, CPOL/CPHA modes 0-3, NUM_SS selects.
// Define SPI_LSB_FIRST_EN to add the lsb_first input (LSB-first shifting in both directions).
module spi_mnrch_param #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 5,
  parameter int NUM_SS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_mnrch_param_if.master bus_io
);
  localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int BC_W  = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] HALF_END = DIV_W'((1 << (DIV_W - 1)) - 1);
  localparam logic [DIV_W-1:0] PER_END  = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FRONT = 2'd1, SHIFT = 2'd2, BACK = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [1:0]        mode_q, mode_d;
  logic              samp_q, samp_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              lsb_s, cpol_s, cpha_s, half_end_s, per_end_s;
  logic [SEL_W-1:0]  sel_s;

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_s = lsb_q;
`else
  assign lsb_s = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                 input logic b, input logic lsb);
    if (lsb) begin
      return {b, v[DATA_W-1:1]};
    end else begin
      return {v[DATA_W-2:0], b};
    end
  endfunction

  assign cpol_s     = mode_q[1];
  assign cpha_s     = mode_q[0];
  assign half_end_s = (div_q == HALF_END);
  assign per_end_s  = (div_q == PER_END);
  // An index past the last select line falls back to slave 0.
  assign sel_s      = (int'(bus_io.ss_sel) < NUM_SS) ? bus_io.ss_sel : {SEL_W{1'b0}};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_io.snd) state_d = FRONT; else state_d = IDLE;
      FRONT:   if (half_end_s) state_d = SHIFT; else state_d = FRONT;
      SHIFT:   if (per_end_s && (bit_q == LAST_BIT)) state_d = BACK; else state_d = SHIFT;
      BACK:    if (half_end_s) state_d = IDLE; else state_d = BACK;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: counters, SCLK edges, sampling and shifting
  always_comb begin
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    mode_d  = mode_q;
    samp_d  = samp_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ss_n_d  = ss_n_q;
`ifdef SPI_LSB_FIRST_EN
    lsb_d   = lsb_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_io.snd) begin
          shreg_d = bus_io.cmd;
          mode_d  = bus_io.mode;
          div_d   = DIV_ZERO;
          bit_d   = {BC_W{1'b0}};
          ss_n_d  = ~(NUM_SS'(1'b1) << sel_s);
          sclk_d  = bus_io.mode[1];
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef SPI_LSB_FIRST_EN
          lsb_d   = bus_io.lsb_first;
`endif
        end else begin
          sclk_d = cpol_s;
        end
      end
      FRONT: begin
        if (half_end_s) begin
          // First leading edge of the transfer.
          div_d  = DIV_ZERO;
          sclk_d = ~cpol_s;
          if (!cpha_s) samp_d = bus_io.MISO; else samp_d = samp_q;
        end else begin
          div_d = div_q + DIV_W'(1'b1);
        end
      end
      SHIFT: begin
        div_d = div_q + DIV_W'(1'b1);
        if (half_end_s) begin
          sclk_d = cpol_s;
          if (cpha_s) samp_d = bus_io.MISO;
          else shreg_d = shift_in(shreg_q, samp_q, lsb_s);
        end else if (per_end_s) begin
          // Period boundary: CPHA=1 shifts here, including the exit edge.
          bit_d = bit_q + BC_W'(1'b1);
          if (cpha_s) shreg_d = shift_in(shreg_q, samp_q, lsb_s); else shreg_d = shreg_q;
          if (bit_q == LAST_BIT) begin
            sclk_d = cpol_s;
          end else begin
            sclk_d = ~cpol_s;
            if (!cpha_s) samp_d = bus_io.MISO; else samp_d = samp_q;
          end
        end else begin
          sclk_d = sclk_q;
        end
      end
      BACK: begin
        if (half_end_s) begin
          div_d  = DIV_ZERO;
          ss_n_d = {NUM_SS{1'b1}};
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1'b1);
        end
      end
      default: begin
        ss_n_d = {NUM_SS{1'b1}};
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= {DATA_W{1'b0}};
      div_q   <= DIV_ZERO;
      bit_q   <= {BC_W{1'b0}};
      mode_q  <= 2'b00;
      samp_q  <= 1'b0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_n_q  <= {NUM_SS{1'b1}};
`ifdef SPI_LSB_FIRST_EN
      lsb_q   <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      mode_q  <= mode_d;
      samp_q  <= samp_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ss_n_q  <= ss_n_d;
`ifdef SPI_LSB_FIRST_EN
      lsb_q   <= lsb_d;
`endif
    end
  end

  assign bus_io.SS_n = ss_n_q;
  assign bus_io.SCLK = sclk_q;
  assign bus_io.MOSI = lsb_s ? shreg_q[0] : shreg_q[DATA_W-1];
  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.resp = shreg_q;
endmodule

// File: tb/tb_spi_mnrch_param.sv
// Scoreboard bench for spi_mnrch_param: behavioural SPI slave, expected results queued at issue.
`timescale 1ns/1ps
module tb_spi_mnrch_param;
  localparam int DATA_W = 16;
  localparam int DIV_W  = 5;
  localparam int NUM_SS = 5;
  localparam int SEL_W  = 3;
  localparam int H      = 1 << (DIV_W - 1);
  localparam int LAT    = 1 + 2 * H + DATA_W * (1 << DIV_W);
  localparam int LIMIT  = LAT + 100;

  typedef struct {
    logic [DATA_W-1:0] cmd;
    logic [DATA_W-1:0] word;
    logic [NUM_SS-1:0] ss_exp;
    int                start;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   ss_err = 0;
  int   last_start = 0;
  item_t sb_q[$];

  // slave model state
  logic [DATA_W-1:0] sl_word, sl_w, sl_rx;
  logic              sl_cpol, sl_cpha, sl_cpol_a, sl_cpha_a, sl_prev;
  bit                sl_on = 1'b0;
  int                sl_idx = 0;
  int                sl_pulses = 0;
  int                sl_idle_err = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_mnrch_param_if #(.DATA_W(DATA_W), .NUM_SS(NUM_SS)) bus_if ();
  spi_mnrch_param #(.DATA_W(DATA_W), .DIV_W(DIV_W), .NUM_SS(NUM_SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus_if.master)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [DATA_W-1:0] c, input logic [1:0] m,
                       input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] w, input bit accept);
    item_t it;
    int    idx;
    @(posedge clk); #1;
    if (accept) begin
      sl_word = w; sl_cpol = m[1]; sl_cpha = m[0];
      idx = (int'(s) < NUM_SS) ? int'(s) : 0;
      for (int i = 0; i < NUM_SS; i++) it.ss_exp[i] = (i != idx);
      it.cmd = c; it.word = w; it.start = cyc;
      last_start = cyc;
      sb_q.push_back(it);
    end
    bus_if.snd = 1'b1; bus_if.cmd = c; bus_if.mode = m; bus_if.ss_sel = s;
    @(posedge clk); #1;
    bus_if.snd = 1'b0; bus_if.cmd = DATA_W'($urandom); bus_if.mode = 2'($urandom);
    bus_if.ss_sel = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_if.done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 64'(n < LIMIT), 64'd1);
  endtask

  // SPI slave: shifts out sl_word MSB-first and collects MOSI, by the mode's edge rules
  initial begin
    bus_if.MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || (&bus_if.SS_n) === 1'b1) begin
        sl_on = 1'b0;
      end else if (!sl_on) begin
        sl_on = 1'b1; sl_w = sl_word; sl_cpol_a = sl_cpol; sl_cpha_a = sl_cpha;
        sl_idx = 0; sl_rx = '0; sl_pulses = 0; sl_prev = bus_if.SCLK;
        if (bus_if.SCLK !== sl_cpol_a) sl_idle_err++;
        if (!sl_cpha_a) begin
          bus_if.MISO = sl_w[DATA_W-1];
          sl_idx = 1;
        end
      end else if (bus_if.SCLK !== sl_prev) begin
        sl_prev = bus_if.SCLK;
        if (bus_if.SCLK !== sl_cpol_a) begin
          sl_pulses++;
          if (!sl_cpha_a) sl_rx = {sl_rx[DATA_W-2:0], bus_if.MOSI};
          else begin
            if (sl_idx < DATA_W) bus_if.MISO = sl_w[DATA_W-1-sl_idx];
            sl_idx++;
          end
        end else begin
          if (sl_cpha_a) sl_rx = {sl_rx[DATA_W-2:0], bus_if.MOSI};
          else begin
            if (sl_idx < DATA_W) bus_if.MISO = sl_w[DATA_W-1-sl_idx];
            sl_idx++;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard when done rises and checks the finished transfer
  initial begin
    logic  done_prev;
    item_t it;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        done_prev = 1'b0;
      end else begin
        if (bus_if.busy === 1'b1 && sb_q.size() > 0) begin
          if (bus_if.SS_n !== sb_q[0].ss_exp) ss_err++;
        end else if (bus_if.SS_n !== {NUM_SS{1'b1}}) begin
          ss_err++;
        end
        if (bus_if.done === 1'b1 && !done_prev) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'(sb_q.size()), 64'd1);
          end else begin
            it = sb_q.pop_front();
            chk("resp", 64'(bus_if.resp), 64'(it.word));
            chk("mosi_word", 64'(sl_rx), 64'(it.cmd));
            chk("latency", 64'(cyc - it.start), 64'(LAT));
            chk("sclk_pulses", 64'(sl_pulses), 64'(DATA_W));
            chk("ss_pattern", 64'(ss_err), 64'd0);
            chk("sclk_idle", 64'(sl_idle_err), 64'd0);
            chk("busy_low_at_done", 64'(bus_if.busy), 64'd0);
            ss_err = 0;
            sl_idle_err = 0;
          end
        end
        done_prev = bus_if.done;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_if.snd = 1'b0; bus_if.cmd = '0; bus_if.mode = 2'b00; bus_if.ss_sel = '0;
`ifdef SPI_LSB_FIRST_EN
    bus_if.lsb_first = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ss_n", 64'(bus_if.SS_n), 64'(5'b11111));
    chk("rst_sclk", 64'(bus_if.SCLK), 64'd0);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_done", 64'(bus_if.done), 64'd0);
    chk("rst_resp", 64'(bus_if.resp), 64'd0);
    chk("rst_mosi", 64'(bus_if.MOSI), 64'd0);

    // directed: mode 0 echo, mode 3, out-of-range select
    issue(16'hA5C3, 2'b00, 3'd0, 16'hA5C3, 1'b1); wait_idle();
    issue(16'h5A0F, 2'b11, 3'd2, 16'h1234, 1'b1); wait_idle();
    issue(16'h8001, 2'b01, 3'd5, 16'h7FFE, 1'b1); wait_idle();

    // snd while busy must be ignored
    issue(16'hC0DE, 2'b01, 3'd3, 16'hBEEF, 1'b1);
    repeat (100) @(posedge clk);
    issue(16'h1111, 2'b10, 3'd1, 16'h0000, 1'b0);
    wait_idle();

    // snd on the cycle done rises must be ignored
    issue(16'h0F0F, 2'b10, 3'd4, 16'hF00D, 1'b1);
    while (cyc < last_start + LAT - 1) begin
      @(posedge clk); #1;
    end
    bus_if.snd = 1'b1; bus_if.cmd = 16'h2222; bus_if.mode = 2'b00; bus_if.ss_sel = 3'd1;
    @(posedge clk); #1;
    bus_if.snd = 1'b0;
    chk("late_snd_done", 64'(bus_if.done), 64'd1);
    chk("late_snd_busy", 64'(bus_if.busy), 64'd0);
    chk("late_snd_ss_n", 64'(bus_if.SS_n), 64'(5'b11111));

    // next accepted snd clears done one cycle later
    issue(16'h3C3C, 2'b00, 3'd1, 16'h9669, 1'b1);
    chk("new_snd_done_clr", 64'(bus_if.done), 64'd0);
    chk("new_snd_busy", 64'(bus_if.busy), 64'd1);
    wait_idle();

    // reset in the middle of a transfer aborts it immediately
    issue(16'hFFFF, 2'b11, 3'd4, 16'h0001, 1'b1);
    repeat (200) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ss_n", 64'(bus_if.SS_n), 64'(5'b11111));
    chk("abort_sclk", 64'(bus_if.SCLK), 64'd0);
    chk("abort_busy", 64'(bus_if.busy), 64'd0);
    chk("abort_done", 64'(bus_if.done), 64'd0);
    sb_q.delete();
    ss_err = 0; sl_idle_err = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // randomized transfers
    for (int i = 0; i < 8; i++) begin
      issue(DATA_W'($urandom), 2'($urandom), 3'($urandom), DATA_W'($urandom), 1'b1);
      wait_idle();
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
